// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI mode-0 slave.
// Build option: define SPI_SLAVE_OVERRUN_EN to drop bytes that arrive while
// the previous byte is still unconsumed, and flag them on rx_overrun.
package spi_pkg;

  localparam int SPI_WORD_W = 8;
  localparam int SPI_SYNC_STAGES = 2;
  localparam int SPI_BITCNT_W = $clog2(SPI_WORD_W);
  localparam logic [SPI_WORD_W-1:0] SPI_UNDERRUN_BYTE = 8'h00;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchroniser for one asynchronous pad plus a history flop, giving
// the synchronised level and one-cycle rise/fall strobes.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                       hist_q, hist_d;

  // Next values: shift the pad into the chain, remember the previous level.
  always_comb begin
    sync_d = {sync_q[SPI_SYNC_STAGES-2:0], din};
    hist_d = sync_q[SPI_SYNC_STAGES-1];
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SPI_SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) with valid/ready byte ports.
// Build option: SPI_SLAVE_OVERRUN_EN enables drop-on-overrun with a one-cycle
// rx_overrun pulse; without it a new byte simply overwrites rx_data.
module spi_slave
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun
);

  // Pads in order {mosi, cs_n, sclk}. All chains reset low: sclk idles low,
  // and a low cs_n chain means a cs_n already low at reset release produces
  // no falling strobe until it has first been seen high.
  localparam int NPAD = 3;
  localparam int P_SCLK = 0;
  localparam int P_CS = 1;
  localparam int P_MOSI = 2;

  logic [NPAD-1:0] pad_in, pad_lvl, pad_rise, pad_fall;
  logic            sync_unused;

  assign pad_in = {mosi, cs_n, sclk};

  generate
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_sync
      spi_slave_sync #(.RST_VAL(1'b0)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pad_in[gi]),
        .level (pad_lvl[gi]),
        .rise  (pad_rise[gi]),
        .fall  (pad_fall[gi])
      );
    end
  endgenerate

  assign sync_unused = ^{pad_lvl[P_SCLK], pad_rise[P_MOSI], pad_fall[P_MOSI]};

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_lvl, mosi_s;
  assign sclk_rise = pad_rise[P_SCLK];
  assign sclk_fall = pad_fall[P_SCLK];
  assign cs_fall   = pad_fall[P_CS];
  assign cs_rise   = pad_rise[P_CS];
  assign cs_lvl    = pad_lvl[P_CS];
  assign mosi_s    = pad_lvl[P_MOSI];

  spi_state_e              state_q, state_d;
  logic [SPI_WORD_W-1:0]   shreg_q, shreg_d;
  logic [SPI_BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic                    miso_q, miso_d;
  logic                    miso_oe_q, miso_oe_d;
  logic [SPI_WORD_W-1:0]   hold_q, hold_d;
  logic                    tx_ready_q, tx_ready_d;
  logic [SPI_WORD_W-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                    rx_overrun_q, rx_overrun_d;
`endif

  logic                  load;
  logic                  new_byte;
  logic [SPI_WORD_W-1:0] load_word;
  logic [SPI_WORD_W-1:0] shifted;

  // Next-state logic: frame FSM, shared shift register, holding register and RX port.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    miso_d     = miso_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_overrun_d = 1'b0;
`endif
    load      = 1'b0;
    new_byte  = 1'b0;
    load_word = SPI_UNDERRUN_BYTE;
    shifted   = {shreg_q[SPI_WORD_W-2:0], mosi_s};

    // Local TX handshake into the one-deep holding register.
    if (tx_valid && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d  = ST_ACTIVE;
          load     = 1'b1;
          bitcnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          // Abandon any partial byte; holding register keeps its contents.
          state_d  = ST_IDLE;
          bitcnt_d = '0;
        end else if (sclk_rise) begin
          if (bitcnt_q == SPI_BITCNT_W'(SPI_WORD_W - 1)) begin
            new_byte = 1'b1;
            load     = 1'b1;
            bitcnt_d = '0;
          end else begin
            shreg_d  = shifted;
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          miso_d = shreg_q[SPI_WORD_W-1];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load the next TX word; an empty holding register sends the underrun byte.
    // An accept in the same cycle sees tx_ready_q=1 and so lands in holding.
    if (load) begin
      if (!tx_ready_q) begin
        load_word  = hold_q;
        tx_ready_d = 1'b1;
      end
      shreg_d = load_word;
      // At frame start the first bit must be on MISO before the first SCLK rise.
      if (state_q == ST_IDLE) begin
        miso_d = load_word[SPI_WORD_W-1];
      end
    end

    // RX port: consumption first, so a simultaneous new byte keeps rx_valid high.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (new_byte) begin
`ifdef SPI_SLAVE_OVERRUN_EN
      if (rx_valid_q && !rx_ready) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d  = shifted;
        rx_valid_d = 1'b1;
      end
`else
      rx_data_d  = shifted;
      rx_valid_d = 1'b1;
`endif
    end

    miso_oe_d = (state_d == ST_ACTIVE) && !cs_lvl;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // Overrun strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= rx_overrun_d;
    end
  end
  assign rx_overrun = rx_overrun_q;
`else
  assign rx_overrun = 1'b0;
`endif

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master plus a queue model of the
// one-deep TX holding register; directed test-plan cases then random bursts.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overrun;

  int total = 0;
  int bad = 0;

  logic [7:0] hold_model[$];
  logic [7:0] b_mo[4];
  logic [7:0] b_mid[4];
  bit         b_mid_en[4];
  bit         b_pre_en;
  logic [7:0] b_pre;

  int ovr_cnt = 0;
  bit mon_en = 1'b0;
  bit txr_low = 1'b0;

  spi_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
    if (mon_en && !tx_ready) txr_low <= 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holding-register model: a load takes the queued byte, else the underrun byte.
  function automatic logic [7:0] model_load();
    if (hold_model.size() > 0) return hold_model.pop_front();
    return 8'h00;
  endfunction

  task automatic tx_push(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 50) begin
      wait_clk(1);
      n++;
    end
    check_val("tx_ready_before_push", tx_ready, (hold_model.size() == 0));
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    hold_model.push_back(d);
  endtask

  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      sclk = 1'b0;
      wait_clk(6);
      sclk = 1'b1;
      mi[i] = miso;
      wait_clk(6);
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end();
    sclk = 1'b0;
    wait_clk(6);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic rx_expect(input logic [7:0] exp);
    int n = 0;
    while (!rx_valid && n < 20) begin
      wait_clk(1);
      n++;
    end
    check_val("rx_valid", rx_valid, 1);
    check_val("rx_data", rx_data, exp);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_burst();
    b_pre_en = 1'b0;
    for (int k = 0; k < 4; k++) b_mid_en[k] = 1'b0;
  endtask

  task automatic run_burst(input string name, input int n, input bit chk_rx);
    logic [7:0] got;
    logic [7:0] exp_rd;
    if (b_pre_en) tx_push(b_pre);
    cs_begin();
    check_val("miso_oe_active", miso_oe, 1);
    exp_rd = model_load();
    for (int k = 0; k < n; k++) begin
      if (b_mid_en[k]) tx_push(b_mid[k]);
      spi_byte(b_mo[k], got);
      $display("txn %s[%0d]: mosi=%02h miso=%02h exp_miso=%02h", name, k, b_mo[k], got, exp_rd);
      check_val("miso_byte", got, exp_rd);
      exp_rd = model_load();
      if (chk_rx) rx_expect(b_mo[k]);
    end
    cs_end();
    check_val("miso_oe_idle", miso_oe, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_miso"}, miso, 0);
    check_val({tag, "_miso_oe"}, miso_oe, 0);
    check_val({tag, "_tx_ready"}, tx_ready, 1);
    check_val({tag, "_rx_data"}, rx_data, 0);
    check_val({tag, "_rx_valid"}, rx_valid, 0);
    check_val({tag, "_rx_overrun"}, rx_overrun, 0);
  endtask

  initial begin
    logic [7:0] junk;
    int ovr_base;

    wait_clk(3);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    wait_clk(4);
    check_reset_outputs("after_reset");

    // Preload A5, master sends 3C.
    clear_burst();
    b_pre_en = 1'b1; b_pre = 8'hA5; b_mo[0] = 8'h3C;
    run_burst("single", 1, 1'b1);

    // Three-byte burst with refills between bytes.
    clear_burst();
    b_pre_en = 1'b1; b_pre = 8'h11;
    b_mid_en[0] = 1'b1; b_mid[0] = 8'h22;
    b_mid_en[1] = 1'b1; b_mid[1] = 8'h33;
    b_mo[0] = 8'hC1; b_mo[1] = 8'hC2; b_mo[2] = 8'hC3;
    run_burst("burst", 3, 1'b1);

    // No preload: underrun byte, tx_ready never drops.
    clear_burst();
    b_mo[0] = 8'h96;
    txr_low = 1'b0;
    mon_en = 1'b1;
    run_burst("underrun", 1, 1'b1);
    mon_en = 1'b0;
    check_val("tx_ready_held", txr_low, 0);

    // Partial byte aborted after 5 rises, then a full byte.
    cs_begin();
    junk = model_load();
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom);
      sclk = 1'b0;
      wait_clk(6);
      sclk = 1'b1;
      wait_clk(6);
    end
    cs_end();
    wait_clk(6);
    $display("txn partial: 5 bits then cs_n high");
    check_val("partial_no_rx_valid", rx_valid, 0);
    clear_burst();
    b_mo[0] = 8'h7E;
    run_burst("after_partial", 1, 1'b1);

    // Two bytes with rx_ready held low.
    clear_burst();
    b_mo[0] = 8'h01; b_mo[1] = 8'h02;
    ovr_base = ovr_cnt;
    run_burst("overrun", 2, 1'b0);
    check_val("ovr_rx_valid", rx_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
    check_val("ovr_rx_data", rx_data, 8'h01);
    check_val("ovr_pulses", ovr_cnt - ovr_base, 1);
`else
    check_val("ovr_rx_data", rx_data, 8'h02);
    check_val("ovr_pulses", ovr_cnt - ovr_base, 0);
`endif
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    check_val("ovr_consumed", rx_valid, 0);

    // Reset mid-byte with holding full, released while cs_n is low.
    clear_burst();
    b_mo[0] = 8'hB7;
    run_burst("pre_reset", 1, 1'b0);
    tx_push(8'h99);
    cs_begin();
    junk = model_load();
    tx_push(8'h44);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'($urandom);
      sclk = 1'b0;
      wait_clk(6);
      sclk = 1'b1;
      wait_clk(6);
    end
    rst_n = 1'b0;
    wait_clk(2);
    hold_model.delete();
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    wait_clk(4);
    spi_byte(8'hF0, junk);
    wait_clk(6);
    $display("txn reset_cs_low: byte clocked while cs_n held low");
    check_val("ignored_rx_valid", rx_valid, 0);
    check_val("ignored_miso_oe", miso_oe, 0);
    check_val("ignored_tx_ready", tx_ready, 1);
    cs_end();
    clear_burst();
    b_mo[0] = 8'h5A;
    run_burst("after_reset", 1, 1'b1);

    // Random bursts against the holding-register model.
    for (int t = 0; t < 12; t++) begin
      int n;
      clear_burst();
      n = $urandom_range(1, 3);
      b_pre_en = 1'($urandom);
      b_pre = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        b_mo[k] = 8'($urandom);
        b_mid_en[k] = 1'($urandom);
        b_mid[k] = 8'($urandom);
      end
      run_burst("rand", n, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
